closest_value_finder: RTL

CLOSEST_VALUE_FINDER -- requirements
Module: closest_value_finder

---
 rtl/closest_value_finder_pkg.sv | 14 +
 rtl/closest_value_finder_less_distance.sv | 21 ++
 rtl/closest_value_finder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/closest_value_finder_pkg.sv
// Shared types and default widths for the closest-value finder.
package closest_value_finder_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefCntW  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFirst,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/closest_value_finder_less_distance.sv
// Combinational selector: returns whichever of dataA/dataB lies closer to reff.
// dataB (the newer sample) wins when the distances are equal.
module LessDistance_circuit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [WIDTH-1:0] reff,
  output logic [WIDTH-1:0] answer
);

  logic [WIDTH-1:0] dist_a;
  logic [WIDTH-1:0] dist_b;

  // Subtract the smaller operand from the larger so the unsigned result never wraps.
  assign dist_a = (dataA >= reff) ? (dataA - reff) : (reff - dataA);
  assign dist_b = (dataB >= reff) ? (dataB - reff) : (reff - dataB);

  assign answer = (dist_b <= dist_a) ? dataB : dataA;

endmodule

// File: rtl/closest_value_finder.sv
// Streams up to 2^CNT_W-1 samples and reports the one closest to a reference,
// with the most recent sample winning ties.
module closest_value_finder
  import closest_value_finder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] reff,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [WIDTH-1:0] best,
  output logic [CNT_W-1:0] best_idx,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reff_q, reff_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [CNT_W-1:0] best_idx_q, best_idx_d;

  logic             accept;
  logic [WIDTH-1:0] answer;
  logic [WIDTH-1:0] dist_best;
  logic [WIDTH-1:0] dist_new;
  logic             tie;
  logic             replace;

  LessDistance_circuit #(
    .WIDTH(WIDTH)
  ) u_less_distance (
    .dataA (best_q),
    .dataB (data_in),
    .reff  (reff_q),
    .answer(answer)
  );

  assign dist_best = (best_q >= reff_q) ? (best_q - reff_q) : (reff_q - best_q);
  assign dist_new  = (data_in >= reff_q) ? (data_in - reff_q) : (reff_q - data_in);
  // The tie flag keeps best_idx moving to the newer sample even when the values match.
  assign tie       = (dist_new == dist_best);
  assign replace   = (answer == data_in) || tie;

  assign data_ready = (state_q == StFirst) || (state_q == StScan);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign accept     = data_valid && data_ready;
  assign best       = best_q;
  assign best_idx   = best_idx_q;

  always_comb begin
    state_d    = state_q;
    reff_d     = reff_q;
    count_d    = count_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    unique case (state_q)
      StIdle: begin
        if (start && (count != '0)) begin
          reff_d  = reff;
          count_d = count;
          idx_d   = '0;
          state_d = StFirst;
        end
      end
      StFirst: begin
        if (accept) begin
          best_d     = data_in;
          best_idx_d = '0;
          idx_d      = CNT_W'(1);
          state_d    = (count_q == CNT_W'(1)) ? StDone : StScan;
        end
      end
      StScan: begin
        if (accept) begin
          if (replace) begin
            best_d     = data_in;
            best_idx_d = idx_q;
          end
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == count_q - CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      reff_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      reff_q     <= reff_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
    end
  end

endmodule
